// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit with valid/ready handshakes.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle.
// Special cases (divide by zero, signed overflow, reserved op) finish in one cycle.
// Optional macro MULDIV_SEQ_FAST_MUL_EN: multiplies use a single-cycle array
// multiplier and bypass CALC; divides are unaffected.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int DW = 2 * WIDTH;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_REM   = 3'd5;
  localparam logic [2:0] OP_REMU  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, opnd, res_r;
  logic [2:0]       op_r;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Request decode on the input operands (used only in the accept cycle)
  logic             is_div_in, sgn_in, div_zero, ovf, fast, skip, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag, skip_res;
`ifdef MULDIV_SEQ_FAST_MUL_EN
  logic [DW-1:0]    fast_prod, fast_s;
`endif

  // Classify the incoming request and compute any single-cycle result
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_div_in = (op >= OP_DIV) && (op <= OP_REMU);
    sgn_in    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_mag     = (sgn_in && a[WIDTH-1]) ? -a : a;
    b_mag     = (sgn_in && b[WIDTH-1]) ? -b : b;
    div_zero  = is_div_in && (b == '0);
    ovf       = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == ONES);
    fast      = 1'b0;
    skip_res  = '0;
    case (op)
      OP_MULH, OP_DIV: neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      OP_REM:          neg_in = a[WIDTH-1];
      default:         neg_in = 1'b0;
    endcase
`ifdef MULDIV_SEQ_FAST_MUL_EN
    fast      = (op <= OP_MULHU);
    fast_prod = DW'(a_mag) * DW'(b_mag);
    fast_s    = neg_in ? -fast_prod : fast_prod;
    if (fast) skip_res = (op == OP_MUL) ? fast_s[WIDTH-1:0] : fast_s[DW-1:WIDTH];
`endif
    if (div_zero)
      skip_res = ((op == OP_DIV) || (op == OP_DIVU)) ? ONES : a;
    else if (ovf)
      skip_res = (op == OP_DIV) ? a : '0;
    skip = (op == OP_RSVD) || div_zero || ovf || fast;
  end

  // One iteration step plus sign-corrected final result
  logic [WIDTH:0]   mul_sum, shifted, trial;
  logic [DW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] step_hi, step_lo, final_res;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    prod    = {mul_sum, lo[WIDTH-1:1]};
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    if (op_r <= OP_MULHU) begin
      step_hi = prod[DW-1:WIDTH];
      step_lo = prod[WIDTH-1:0];
    end else begin
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], ~trial[WIDTH]};
    end
    prod_s = neg ? -prod : prod;
    case (op_r)
      OP_MUL:           final_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHU: final_res = prod_s[DW-1:WIDTH];
      OP_DIV, OP_DIVU:  final_res = neg ? -step_lo : step_lo;
      OP_REM, OP_REMU:  final_res = neg ? -step_hi : step_hi;
      default:          final_res = '0;
    endcase
  end

  // FSM next state and handshake outputs; kill overrides everything but reset
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid && !kill;
        if (accept) state_nxt = skip ? DONE : CALC;
      end
      CALC: if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  assign result = out_valid ? res_r : '0;

  // State register with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load operands on accept, iterate in CALC, latch result on the last step
  // NOTE: datapath registers are reset too, so a reset leaves no stale result or count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      res_r <= '0;
      op_r  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_r <= op;
      neg  <= neg_in;
      cnt  <= '0;
      hi   <= '0;
      if (skip) begin
        res_r <= skip_res;
      end else if (op <= OP_MULHU) begin
        lo   <= b_mag;
        opnd <= a_mag;
      end else begin
        lo   <= a_mag;
        opnd <= b_mag;
      end
    end else if (state == CALC) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + 1'b1;
      if (cnt == LAST_CNT) res_r <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven vectors, directed handshake/kill/reset sequences,
// and randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam int W = 32;
`ifdef MULDIV_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, in_valid, kill, out_ready;
  logic         in_ready, out_valid, busy;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i, result;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op_i), .a(a_i), .b(b_i), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model straight from the arithmetic definitions
  function automatic logic [W-1:0] ref_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy, sp;
    logic [63:0] ux, uy, up;
    logic        ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin sp = sx * sy; return sp[31:0]; end
      3'd1: begin sp = sx * sy; return sp[63:32]; end
      3'd2: begin up = ux * uy; return up[63:32]; end
      3'd3: begin
        if (y == 0) return '1;
        if (ovf) return x;
        sp = sx / sy; return sp[31:0];
      end
      3'd4: return (y == 0) ? '1 : x / y;
      3'd5: begin
        if (y == 0) return x;
        if (ovf) return '0;
        sp = sx % sy; return sp[31:0];
      end
      3'd6: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (o == 3'd7) return 1;
    if (o <= 3'd2) return MUL_LAT;
    if (y == 0) return 1;
    if ((o == 3'd3 || o == 3'd5) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Issue one request, scramble inputs after accept, wait (bounded) for the result,
  // then complete the handshake.
  task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     output logic [W-1:0] res, output int lat);
    @(negedge clk);
    op_i = o; a_i = x; b_i = y; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] res, hold;
  int           lat;
  logic         seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    rst = 1'b0;

    vecs.push_back('{"div -7/2",       3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{"rem -7/2",       3'd5, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{"divu 100/0",     3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"remu 100/0",     3'd6, 32'd100,       32'd0,         32'd100,       1});
    vecs.push_back('{"div ovf",        3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem ovf",        3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{"mulh min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
    vecs.push_back('{"mulhu ones",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{"mul ones",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         MUL_LAT});
    vecs.push_back('{"divu 1000/3",    3'd4, 32'd1000,      32'd3,         32'd333,       DIV_LAT});
    vecs.push_back('{"remu 1000/3",    3'd6, 32'd1000,      32'd3,         32'd1,         DIV_LAT});
    vecs.push_back('{"rem 7/-2",       3'd5, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT});
    vecs.push_back('{"div 5/0",        3'd3, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem -5/0",       3'd5, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
    vecs.push_back('{"reserved op",    3'd7, 32'd5,         32'd6,         32'd0,         1});
    vecs.push_back('{"mulh -3*5",      3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, MUL_LAT});

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, " result"}, res, vecs[i].exp);
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
      check({vecs[i].name, " valid drop"}, out_valid, 0);
    end

    // Backpressure: result held stable and no new accept while out_ready is low
    @(negedge clk);
    op_i = 3'd3; a_i = 32'hFFFF_FFF9; b_i = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("bp valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("bp result stable", result, 32'hFFFF_FFFD);
      check("bp in_ready low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp in_ready after handshake", in_ready, 1);
    check("bp valid after handshake", out_valid, 0);
    check("bp result zero", result, 0);

    // Kill at CALC cycle 10 of divu 1000/3
    @(negedge clk);
    op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", busy, 0);
    check("kill in_ready", in_ready, 1);
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("kill no result", seen, 0);
    run(3'd0, 32'd6, 32'd7, res, lat);
    check("mul after kill", res, 32'd42);

    // Kill beats a same-cycle accept
    @(negedge clk);
    op_i = 3'd4; a_i = 32'd9; b_i = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("kill vs accept busy", busy, 0);

    // Reset while DONE with out_ready low
    @(negedge clk);
    op_i = 3'd4; a_i = 32'd100; b_i = 32'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst pre valid", out_valid, 1);
    rst = 1'b1; kill = 1'b1;
    @(negedge clk);
    rst = 1'b0; kill = 1'b0;
    check("rst done valid", out_valid, 0);
    check("rst done result", result, 0);
    check("rst done in_ready", in_ready, 1);
    check("rst done busy", busy, 0);

    // Reset mid-CALC: no result may ever appear
    @(negedge clk);
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst calc no result", seen, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: x = '0;
        1: x = 32'h8000_0000;
        2: x = '1;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'h8000_0000;
        2: y = '1;
        default: y = $urandom;
      endcase
      run(o, x, y, res, lat);
      check($sformatf("rand op%0d %h %h result", o, x, y), res, ref_res(o, x, y));
      check($sformatf("rand op%0d latency", o), lat, ref_lat(o, x, y));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
